dma_write_block: RTL and testbench

// - Write half of the DMA engine. Queues write commands {bytes, dest addr} from the descriptor processor.
// - For each command, pops 256-bit beats from the DMA data FIFO and issues one AVMM burst write to the destination.
// - Pulses a completion strobe back to the descriptor processor when each command finishes.
// - Sits between the descriptor processor, the DMA data FIFO (filled by the read block) and the AVMM write master port.

---
 rtl/dma_write_block.sv | 187 ++++++++++++++++++
 tb/tb_dma_write_block.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_write_block.sv
// ---------------------------------------------------------------------------
// dma_write_block
// Write half of the DMA engine. Write commands {bytes, dest addr} from the
// descriptor processor are queued in a small command FIFO. For each command
// the block pops 256-bit beats from the DMA data FIFO (show-ahead, filled by
// the read block) and issues one AVMM burst write to the destination, then
// pulses a completion strobe.
//
// Ports
//   clk, reset_n                  clock, asynchronous active-low reset
//   dma_wr_fifo_command_req_i     push {bytes, addr} into the command FIFO
//   dma_wr_bytes_to_transfer_i    command byte count
//   dma_wr_addr_i                 destination byte address (passed through)
//   dma_wr_fifo_full_o            command FIFO full
//   dma_wr_done_o                 1-cycle pulse per completed command
//   dma_wr_busy_o                 engine active or commands pending
//   dma_wr_data_i/_empty_i        DMA data FIFO head / empty
//   dma_wr_data_rdreq_o           DMA data FIFO pop
//   dma_dest_addr_o/_bcount_o     AVMM address / burstcount, held per burst
//   dma_dest_write_o/_data_o      AVMM write / writedata
//   dma_dest_wait_req_i           AVMM waitrequest
//   dma_dest_byteenable_o         AVMM byteenable (only with the macro below)
//
// Configuration
//   DMA_WR_BYTE_ENABLE_EN  when defined, adds dma_dest_byteenable_o so a
//                          partial final beat writes only its valid bytes.
// ---------------------------------------------------------------------------
module dma_write_block #(
  parameter int CMD_DEPTH = 32,
  parameter int CMD_AW    = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         dma_wr_fifo_command_req_i,
  input  logic [15:0]  dma_wr_bytes_to_transfer_i,
  input  logic [31:0]  dma_wr_addr_i,
  output logic         dma_wr_fifo_full_o,
  output logic         dma_wr_done_o,
  output logic         dma_wr_busy_o,
  input  logic [255:0] dma_wr_data_i,
  input  logic         dma_wr_data_empty_i,
  output logic         dma_wr_data_rdreq_o,
  output logic [31:0]  dma_dest_addr_o,
  output logic [10:0]  dma_dest_bcount_o,
  output logic         dma_dest_write_o,
  output logic [255:0] dma_dest_data_o,
  input  logic         dma_dest_wait_req_i
`ifdef DMA_WR_BYTE_ENABLE_EN
  ,
  output logic [31:0]  dma_dest_byteenable_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_CMD,
    S_LD_REG,
    S_BURST,
    S_DONE
  } state_t;

  state_t r_state, w_next;

  // ------------------------------------------------------------------ cmd FIFO
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [47:0]     r_cmd_mem [CMD_DEPTH];
  logic [CMD_AW:0] r_wr_ptr, r_rd_ptr;
  logic [47:0]     r_cmd_q;
  logic            w_empty, w_full, w_push, w_pop;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[CMD_AW] != r_rd_ptr[CMD_AW]) &&
                   (r_wr_ptr[CMD_AW-1:0] == r_rd_ptr[CMD_AW-1:0]);
  assign w_push  = dma_wr_fifo_command_req_i & ~w_full;
  assign w_pop   = (r_state == S_RD_CMD) & ~w_empty;

  // NOTE: the storage array has no reset; only the pointers define FIFO
  // contents, so clearing them empties the FIFO and keeps the array in RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_cmd_mem[r_wr_ptr[CMD_AW-1:0]] <= {dma_wr_bytes_to_transfer_i, dma_wr_addr_i};
  end

  // NOTE: state elements use non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cmd_q  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_cmd_q  <= r_cmd_mem[r_rd_ptr[CMD_AW-1:0]];
      end
    end
  end

  // ------------------------------------------------------------ beat count
  // Round the byte count up to whole 32-byte beats; only byte counts above
  // 65504 overflow the 11-bit burstcount and are clamped to 2047.
  logic [11:0] w_beats_raw;
  logic [10:0] w_beats;

  assign w_beats_raw = {1'b0, r_cmd_q[47:37]} + {11'd0, |r_cmd_q[36:32]};
  assign w_beats     = w_beats_raw[11] ? 11'h7FF : w_beats_raw[10:0];

  // ------------------------------------------------------------- datapath
  logic [31:0] r_addr;
  logic [10:0] r_bcount;
  logic [10:0] r_cnt;
  logic        w_write, w_accept, w_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr   <= '0;
      r_bcount <= '0;
      r_cnt    <= '0;
    end else if (r_state == S_LD_REG) begin
      r_addr   <= r_cmd_q[31:0];
      r_bcount <= w_beats;
      r_cnt    <= w_beats;
    end else if (w_accept) begin
      r_cnt    <= r_cnt - 11'd1;
    end
  end

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    w_next   = r_state;
    w_write  = 1'b0;
    w_accept = 1'b0;
    w_done   = 1'b0;
    unique case (r_state)
      S_IDLE:   if (!w_empty) w_next = S_RD_CMD;
      S_RD_CMD: w_next = S_LD_REG;
      S_LD_REG: w_next = (w_beats == 11'd0) ? S_DONE : S_BURST;
      S_BURST: begin
        // An empty data FIFO just bubbles the burst; addr/bcount stay held.
        w_write  = ~dma_wr_data_empty_i;
        w_accept = w_write & ~dma_dest_wait_req_i;
        if (w_accept && (r_cnt == 11'd1)) w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

`ifdef DMA_WR_BYTE_ENABLE_EN
  // Residual byte count of the command, used to trim the final beat.
  logic [4:0]  r_rem;
  logic [31:0] w_be;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                   r_rem <= '0;
    else if (r_state == S_LD_REG)   r_rem <= r_cmd_q[36:32];
  end

  always_comb begin
    w_be = '1;
    if ((r_cnt == 11'd1) && (r_rem != 5'd0)) w_be = (32'd1 << r_rem) - 32'd1;
  end

  assign dma_dest_byteenable_o = w_be;
`endif

  // -------------------------------------------------------------- outputs
  assign dma_wr_fifo_full_o  = w_full;
  assign dma_wr_done_o       = w_done;
  assign dma_wr_busy_o       = (r_state != S_IDLE) | ~w_empty;
  assign dma_wr_data_rdreq_o = w_accept;
  assign dma_dest_addr_o     = r_addr;
  assign dma_dest_bcount_o   = r_bcount;
  assign dma_dest_write_o    = w_write;
  assign dma_dest_data_o     = dma_wr_data_i;

endmodule

// File: tb/tb_dma_write_block.sv
// ---------------------------------------------------------------------------
// tb_dma_write_block
// Directed bench for dma_write_block. A small model of the DMA data FIFO
// feeds the DUT; every tracked command pushes its expected beats
// (addr, bcount, data, byteenable) onto a scoreboard, and a negedge monitor
// pops and compares each beat the DUT writes.
// ---------------------------------------------------------------------------
module tb_dma_write_block;

  typedef struct {
    logic [31:0]  addr;
    logic [10:0]  bcount;
    logic [255:0] data;
    logic [31:0]  be;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         dma_wr_fifo_command_req_i;
  logic [15:0]  dma_wr_bytes_to_transfer_i;
  logic [31:0]  dma_wr_addr_i;
  logic         dma_wr_fifo_full_o;
  logic         dma_wr_done_o;
  logic         dma_wr_busy_o;
  logic [255:0] dma_wr_data_i;
  logic         dma_wr_data_empty_i;
  logic         dma_wr_data_rdreq_o;
  logic [31:0]  dma_dest_addr_o;
  logic [10:0]  dma_dest_bcount_o;
  logic         dma_dest_write_o;
  logic [255:0] dma_dest_data_o;
  logic         dma_dest_wait_req_i;
`ifdef DMA_WR_BYTE_ENABLE_EN
  logic [31:0]  dma_dest_byteenable_o;
`endif

  dma_write_block dut (
    .clk                        (clk),
    .reset_n                    (reset_n),
    .dma_wr_fifo_command_req_i  (dma_wr_fifo_command_req_i),
    .dma_wr_bytes_to_transfer_i (dma_wr_bytes_to_transfer_i),
    .dma_wr_addr_i              (dma_wr_addr_i),
    .dma_wr_fifo_full_o         (dma_wr_fifo_full_o),
    .dma_wr_done_o              (dma_wr_done_o),
    .dma_wr_busy_o              (dma_wr_busy_o),
    .dma_wr_data_i              (dma_wr_data_i),
    .dma_wr_data_empty_i        (dma_wr_data_empty_i),
    .dma_wr_data_rdreq_o        (dma_wr_data_rdreq_o),
    .dma_dest_addr_o            (dma_dest_addr_o),
    .dma_dest_bcount_o          (dma_dest_bcount_o),
    .dma_dest_write_o           (dma_dest_write_o),
    .dma_dest_data_o            (dma_dest_data_o),
    .dma_dest_wait_req_i        (dma_dest_wait_req_i)
`ifdef DMA_WR_BYTE_ENABLE_EN
    ,
    .dma_dest_byteenable_o      (dma_dest_byteenable_o)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ------------------------------------------------------ data FIFO model
  logic [255:0] dmem [4096];
  int           wp;
  int           rp;

  assign dma_wr_data_i       = dmem[rp[11:0]];
  assign dma_wr_data_empty_i = (wp == rp);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 rp <= 0;
    else if (dma_wr_data_rdreq_o) rp <= rp + 1;
  end

  // ------------------------------------------------------------ checking
  int    n_checks = 0;
  int    n_err    = 0;
  beat_t sb[$];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] pat(input int c, input int b);
    logic [31:0] w;
    w = {c[15:0], b[15:0]} ^ 32'hA5C3_0F00;
    return {w, ~w, w + 32'd1, w ^ 32'h5555_5555, w, ~w, w - 32'd1, w ^ 32'h0F0F_0F0F};
  endfunction

  function automatic int beats_of(input int bytes);
    int n;
    n = (bytes + 31) / 32;
    return (n > 2047) ? 2047 : n;
  endfunction

  // ------------------------------------------------------------- monitor
  int wr_cycles    = 0;
  int acc_cnt      = 0;
  int rd_cnt       = 0;
  int done_cnt     = 0;
  int done_cyc     = 0;
  int last_acc_cyc = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      check("rdreq_rule", dma_wr_data_rdreq_o, dma_dest_write_o & ~dma_dest_wait_req_i);
      check("write_without_data", dma_dest_write_o & dma_wr_data_empty_i, 1'b0);
      if (dma_wr_data_rdreq_o) rd_cnt++;
      if (dma_dest_write_o) begin
        wr_cycles++;
        check("sb_nonempty", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          check("beat_addr", dma_dest_addr_o, sb[0].addr);
          check("beat_bcount", dma_dest_bcount_o, sb[0].bcount);
          if (!dma_dest_wait_req_i) begin
            beat_t e;
            e = sb.pop_front();
            check("beat_data", dma_dest_data_o, e.data);
`ifdef DMA_WR_BYTE_ENABLE_EN
            check("beat_be", dma_dest_byteenable_o, e.be);
`endif
            acc_cnt++;
            last_acc_cyc = cyc;
          end
        end
      end
      if (dma_wr_done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // ------------------------------------------------------- stimulus helpers
  int next_cid = 0;
  int exp_done = 0;
  int c_n      = 0;

  task automatic load_beats(input int cid, input int n);
    for (int b = 0; b < n; b++) begin
      dmem[wp[11:0]] = pat(cid, b);
      wp++;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the push edge.
  task automatic push_cmd(input int bytes, input logic [31:0] addr, input bit track);
    int n;
    n = beats_of(bytes);
    dma_wr_fifo_command_req_i  = 1'b1;
    dma_wr_bytes_to_transfer_i = bytes[15:0];
    dma_wr_addr_i              = addr;
    if (track) begin
      for (int b = 0; b < n; b++) begin
        beat_t e;
        e.addr   = addr;
        e.bcount = n[10:0];
        e.data   = pat(next_cid, b);
        e.be     = ((b == n - 1) && (bytes % 32 != 0)) ? ((32'd1 << (bytes % 32)) - 32'd1) : '1;
        sb.push_back(e);
      end
      exp_done++;
      next_cid++;
    end
    @(posedge clk);
    #1;
    dma_wr_fifo_command_req_i = 1'b0;
    c_n = cyc;
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done_cnt >= target) break;
      @(posedge clk);
      #1;
    end
    check("done_count", done_cnt, target);
  endtask

  task automatic wait_write(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (dma_dest_write_o) break;
      @(posedge clk);
      #1;
    end
    check("write_seen", dma_dest_write_o, 1'b1);
  endtask

  // ------------------------------------------------------------ sequence
  initial begin
    int cid;
    int a0, r0, w0, d0;

    reset_n                    = 1'b0;
    dma_wr_fifo_command_req_i  = 1'b0;
    dma_wr_bytes_to_transfer_i = '0;
    dma_wr_addr_i              = '0;
    dma_dest_wait_req_i        = 1'b0;
    wp                         = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_full", dma_wr_fifo_full_o, 1'b0);
    check("rst_busy", dma_wr_busy_o, 1'b0);
    check("rst_write", dma_dest_write_o, 1'b0);
    check("rst_done", dma_wr_done_o, 1'b0);
    check("rst_rdreq", dma_wr_data_rdreq_o, 1'b0);
    check("rst_addr", dma_dest_addr_o, 32'h0);
    check("rst_bcount", dma_dest_bcount_o, 11'h0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // 64 bytes, data preloaded, no waitrequest.
    cid = next_cid; load_beats(cid, 2);
    a0 = acc_cnt; r0 = rd_cnt; w0 = wr_cycles; d0 = done_cnt;
    push_cmd(64, 32'h0000_1000, 1'b1);
    wait_write(10);
    check("t1_latency", cyc - c_n, 3);
    wait_done(exp_done, 20);
    check("t1_write_cycles", wr_cycles - w0, 2);
    check("t1_rdreq", rd_cnt - r0, 2);
    check("t1_beats", acc_cnt - a0, 2);
    check("t1_done_lat", done_cyc - last_acc_cyc, 1);
    check("t1_done_once", done_cnt - d0, 1);

    // 33 bytes: two beats, partial final beat.
    cid = next_cid; load_beats(cid, 2);
    a0 = acc_cnt;
    push_cmd(33, 32'h0000_2000, 1'b1);
    wait_done(exp_done, 20);
    check("t2_beats", acc_cnt - a0, 2);

    // 96 bytes with waitrequest on beat 2 and a data bubble before beat 3.
    cid = next_cid; load_beats(cid, 2);
    a0 = acc_cnt; d0 = done_cnt;
    push_cmd(96, 32'h0000_3000, 1'b1);
    wait_write(10);
    @(posedge clk); #1;
    dma_dest_wait_req_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    dma_dest_wait_req_i = 1'b0;
    @(posedge clk); #1;
    check("t3_bubble_write", dma_dest_write_o, 1'b0);
    check("t3_bubble_addr", dma_dest_addr_o, 32'h0000_3000);
    check("t3_bubble_bcount", dma_dest_bcount_o, 11'd3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    load_beats(cid + 0, 0);
    dmem[wp[11:0]] = pat(cid, 2);
    wp++;
    wait_done(exp_done, 20);
    check("t3_beats", acc_cnt - a0, 3);
    check("t3_done_once", done_cnt - d0, 1);

    // Zero bytes: no write, no pop, done three cycles after the push.
    r0 = rd_cnt; w0 = wr_cycles;
    push_cmd(0, 32'h0000_7000, 1'b1);
    wait_done(exp_done, 20);
    check("t4_done_lat", done_cyc - c_n, 3);
    check("t4_no_write", wr_cycles - w0, 0);
    check("t4_no_rdreq", rd_cnt - r0, 0);

    // Stall the engine, fill the command FIFO, drop one push.
    cid = next_cid;
    push_cmd(32, 32'h0000_4000, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("t5_stalled_write", dma_dest_write_o, 1'b0);
    check("t5_stalled_busy", dma_wr_busy_o, 1'b1);
    for (int i = 1; i < 32; i++) push_cmd(32, 32'h0000_4000 + i * 32, 1'b1);
    check("t5_not_full_31", dma_wr_fifo_full_o, 1'b0);
    push_cmd(32, 32'h0000_4000 + 32 * 32, 1'b1);
    check("t5_full_32", dma_wr_fifo_full_o, 1'b1);
    push_cmd(32, 32'h0000_DEAD, 1'b0);
    check("t5_still_full", dma_wr_fifo_full_o, 1'b1);
    for (int i = 0; i < 33; i++) begin
      dmem[wp[11:0]] = pat(cid + i, 0);
      wp++;
    end
    wait_done(exp_done, 600);
    check("t5_sb_empty", sb.size(), 0);
    check("t5_idle", dma_wr_busy_o, 1'b0);

    // Max byte count clamps to 2047, then reset mid-burst with FIFO full.
    cid = next_cid; load_beats(cid, 4);
    dma_dest_wait_req_i = 1'b1;
    push_cmd(65535, 32'h0000_5000, 1'b1);
    wait_write(10);
    check("t6_bcount_clamp", dma_dest_bcount_o, 11'd2047);
    check("t6_addr", dma_dest_addr_o, 32'h0000_5000);
    dma_dest_wait_req_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    dma_dest_wait_req_i = 1'b1;
    for (int i = 0; i < 32; i++) push_cmd(32, 32'h0000_8000, 1'b0);
    check("t6_full", dma_wr_fifo_full_o, 1'b1);
    check("t6_write_pre", dma_dest_write_o, 1'b1);
    #2;
    reset_n = 1'b0;
    wp      = 0;
    #1;
    check("t6_rst_write", dma_dest_write_o, 1'b0);
    check("t6_rst_rdreq", dma_wr_data_rdreq_o, 1'b0);
    check("t6_rst_busy", dma_wr_busy_o, 1'b0);
    check("t6_rst_full", dma_wr_fifo_full_o, 1'b0);
    check("t6_rst_addr", dma_dest_addr_o, 32'h0);
    sb.delete();
    exp_done = done_cnt;
    dma_dest_wait_req_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("t6_post_busy", dma_wr_busy_o, 1'b0);
    check("t6_post_full", dma_wr_fifo_full_o, 1'b0);
    check("t6_post_write", dma_dest_write_o, 1'b0);

    // Engine works again after reset.
    cid = next_cid; load_beats(cid, 1);
    a0 = acc_cnt;
    push_cmd(32, 32'h0000_6000, 1'b1);
    wait_done(exp_done, 20);
    check("t7_beats", acc_cnt - a0, 1);
    check("final_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
